pwm_ctrl_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-output counter-driven control generator.
- One shared free-running period counter drives N_CH independent duty comparators, giving N_CH registered PWM control outputs.
- Period and duty values are programmable at run time through a load strobe.
- Double-buffered so a new setting takes effect only at a period boundary (glitch-free).
- Sits between a control/config source and actuator-style outputs; `o_tick` marks period ends for downstream sequencing.

---
 rtl/pwm_ctrl_pkg.sv | 15 +
 rtl/pwm_ctrl_chan.sv | 44 ++++
 rtl/pwm_ctrl_multi.sv | 87 ++++++++
 tb/tb_pwm_ctrl_multi.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared helpers for the multi-channel PWM controller.
// Default-period value and per-channel duty slice offset.
package pwm_ctrl_pkg;

    // All-ones period: longest possible period for a given counter width.
    function automatic int def_period(input int w);
        return (1 << w) - 1;
    endfunction

    // LSB offset of channel k inside a packed duty bus.
    function automatic int chan_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pwm_ctrl_chan.sv
// One PWM channel: double-buffered duty value, comparator, output flop.
// Ports: clock/reset, i_enable, i_load, i_apply, i_duty, i_cnt -> o_ctrl.
module pwm_ctrl_chan #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic             i_apply,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_ctrl
);

    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             ctrl_q, ctrl_d;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        // Compare uses the active duty before any apply this cycle.
        ctrl_d     = i_enable && (i_cnt < duty_act_q);
        // Apply takes the old shadow even if a load lands the same cycle.
        if (i_apply) duty_act_d = duty_sh_q;
        if (i_load)  duty_sh_d  = i_duty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign o_ctrl = ctrl_q;

endmodule

// File: rtl/pwm_ctrl_multi.sv
// N_CH-channel PWM generator sharing one period counter, glitch-free reload.
// Ports: clock/reset, i_enable, i_load, i_period, i_duty -> o_ctrl, o_tick, o_pending.
module pwm_ctrl_multi
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int N_CH       = 2,
    parameter int DEF_PERIOD = def_period(WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_period,
    input  logic [N_CH*WIDTH-1:0] i_duty,
    output logic [N_CH-1:0]       o_ctrl,
    output logic                  o_tick,
    output logic                  o_pending
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;

    assign wrap  = (cnt_q == per_act_q);
    // While halted there is no boundary to wait for: apply at once.
    assign apply = pend_q && (!i_enable || wrap);

    always_comb begin
        cnt_d     = '0;
        per_act_d = per_act_q;
        per_sh_d  = per_sh_q;
        pend_d    = pend_q;
        tick_d    = i_enable && wrap;
        if (i_enable && !wrap) cnt_d = cnt_q + 1'b1;
        if (apply) begin
            per_act_d = per_sh_q;
            pend_d    = 1'b0;
        end
        // A load on an apply cycle refills the shadow and stays pending.
        if (i_load) begin
            per_sh_d = i_period;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            per_act_q <= DEF_P;
            per_sh_q  <= DEF_P;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_act_q <= per_act_d;
            per_sh_q  <= per_sh_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_ctrl_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .i_enable(i_enable),
            .i_load  (i_load),
            .i_apply (apply),
            .i_duty  (i_duty[chan_lo(k, WIDTH) +: WIDTH]),
            .i_cnt   (cnt_q),
            .o_ctrl  (o_ctrl[k])
        );
    end

    assign o_tick    = tick_q;
    assign o_pending = pend_q;

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Directed bench for pwm_ctrl_multi (WIDTH=5, N_CH=2).
// Counts highs/ticks over windows and checks against hand-derived values.
module tb_pwm_ctrl_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [4:0] period;
    logic [9:0] duty;
    logic [1:0] ctrl;
    logic       tick;
    logic       pend;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_ctrl_multi #(
        .WIDTH(5),
        .N_CH (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_enable (en),
        .i_load   (load),
        .i_period (period),
        .i_duty   (duty),
        .o_ctrl   (ctrl),
        .o_tick   (tick),
        .o_pending(pend)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n, output int c0, output int c1,
                       output int ct);
        c0 = 0;
        c1 = 0;
        ct = 0;
        repeat (n) begin
            step();
            c0 += int'(ctrl[0]);
            c1 += int'(ctrl[1]);
            ct += int'(tick);
        end
    endtask

    task automatic do_load(input int p, input int d0, input int d1);
        load   = 1'b1;
        period = 5'(p);
        duty   = {5'(d1), 5'(d0)};
        step();
        load   = 1'b0;
    endtask

    int c0, c1, ct;
    int guard;

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        period = '0;
        duty   = '0;

        // Reset state, then defaults: duty 0, period 31.
        step();
        step();
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pend", int'(pend), 0);
        reset = 1'b0;
        en    = 1'b1;
        run(32, c0, c1, ct);
        chk("def_tick_a", ct, 1);
        chk("def_ctrl", c0 + c1, 0);
        run(32, c0, c1, ct);
        chk("def_tick_b", ct, 1);

        // Load while disabled.
        en = 1'b0;
        step();
        chk("dis_ctrl", int'(ctrl), 0);
        chk("dis_tick", int'(tick), 0);
        do_load(9, 3, 7);
        chk("dis_pend", int'(pend), 1);
        step();
        chk("dis_apply", int'(pend), 0);
        chk("dis_ctrl2", int'(ctrl), 0);
        en = 1'b1;
        step();
        chk("first_hi", int'(ctrl), 3);
        run(9, c0, c1, ct);
        chk("p10_c0_a", c0, 2);
        chk("p10_c1_a", c1, 6);
        chk("p10_tk_a", ct, 1);
        run(10, c0, c1, ct);
        chk("p10_c0_b", c0, 3);
        chk("p10_c1_b", c1, 7);
        chk("p10_tk_b", ct, 1);

        // Duty boundaries: 0 and above period.
        do_load(9, 0, 31);
        guard = 0;
        while (pend && guard < 40) begin
            step();
            guard++;
        end
        chk("bnd_apply", int'(pend), 0);
        step();
        run(20, c0, c1, ct);
        chk("bnd_c0", c0, 0);
        chk("bnd_c1", c1, 20);
        chk("bnd_tk", ct, 2);

        // Mid-period load at cnt=4.
        guard = 0;
        while (!tick && guard < 40) begin
            step();
            guard++;
        end
        chk("sync_tick", int'(tick), 1);
        run(4, c0, c1, ct);
        do_load(4, 2, 5);
        chk("mid_pend", int'(pend), 1);
        run(4, c0, c1, ct);
        chk("mid_hold", int'(pend), 1);
        chk("mid_notk", ct, 0);
        step();
        chk("mid_wrap_tk", int'(tick), 1);
        chk("mid_wrap_pd", int'(pend), 0);
        run(10, c0, c1, ct);
        chk("p5_c0", c0, 4);
        chk("p5_c1", c1, 10);
        chk("p5_tk", ct, 2);

        // Pending A, then load B exactly on the wrap.
        do_load(6, 1, 3);
        run(3, c0, c1, ct);
        do_load(0, 1, 0);
        chk("wrap_tk", int'(tick), 1);
        chk("wrap_pend", int'(pend), 1);
        run(6, c0, c1, ct);
        chk("a_c0", c0, 1);
        chk("a_c1", c1, 3);
        chk("a_tk", ct, 0);
        chk("a_pend", int'(pend), 1);
        step();
        chk("b_tk", int'(tick), 1);
        chk("b_pend", int'(pend), 0);
        run(8, c0, c1, ct);
        chk("p0_tk", ct, 8);
        chk("p0_c0", c0, 8);
        chk("p0_c1", c1, 0);

        // Reset mid-period with a load pending.
        do_load(9, 3, 7);
        chk("r_pend", int'(pend), 1);
        step();
        chk("r_apply", int'(pend), 0);
        run(5, c0, c1, ct);
        chk("r_c0", c0, 3);
        chk("r_c1", c1, 5);
        do_load(2, 1, 1);
        chk("r_pend2", int'(pend), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r_ctrl", int'(ctrl), 0);
        chk("r_tick", int'(tick), 0);
        chk("r_pend3", int'(pend), 0);
        run(31, c0, c1, ct);
        chk("r_def_tk", ct, 0);
        chk("r_def_ct", c0 + c1, 0);
        step();
        chk("r_def_wrap", int'(tick), 1);
        chk("r_def_pend", int'(pend), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
